usr_seq: RTL and testbench

Sequencer for the 4-bit universal shift register (USR) datapath. It accepts transmit or receive commands over a valid/ready handshake, then drives the register's mode select, parallel input and serial inputs to load a word and shift it out bit-serially, or to shift a word in and return it. Each bit is held for a programmable number of clocks. It sits between a command source and one USR instance, and observes the register contents through `usr_q`.

---
 rtl/usr_seq.sv | 155 +++++++++++++++
 tb/tb_usr_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_seq.sv
// Command sequencer for a W-bit universal shift register: loads a word and
// shifts it out (TX) or shifts a word in and returns it (RX), DIV clocks per bit.
module usr_seq #(
  parameter int W   = 4,
  parameter int DIV = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic         cmd_msb_first,
  input  logic [W-1:0] cmd_data,
  input  logic         abort,
  input  logic         ser_in,
  output logic         ser_out,
  output logic         bit_valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [1:0]   usr_s,
  output logic [W-1:0] usr_din,
  output logic         usr_sil,
  output logic         usr_sir,
  input  logic [W-1:0] usr_q
);

  localparam int CNT_W = $clog2(W + 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [1:0]       state_reg, state_next;
  logic             op_reg;
  logic             msb_first_reg;
  logic [W-1:0]     data_reg;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;

  logic in_idle, in_load, in_shift, in_resp;
  logic cmd_fire;
  logic shift_cycle;
  logic last_bit;

  assign in_idle  = (state_reg == ST_IDLE);
  assign in_load  = (state_reg == ST_LOAD);
  assign in_shift = (state_reg == ST_SHIFT);
  assign in_resp  = (state_reg == ST_RESP);

  assign cmd_fire = in_idle && cmd_valid;

  // An abort suppresses the shift that would otherwise happen in the same cycle.
  assign shift_cycle = in_shift && (div_cnt_reg == DIV_LAST) && !abort;
  assign last_bit    = (bit_cnt_reg == BIT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_next = abort ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (shift_cycle && last_bit) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    div_cnt_next = div_cnt_reg;
    if (in_load || (in_shift && abort)) begin
      bit_cnt_next = '0;
      div_cnt_next = '0;
    end else if (shift_cycle) begin
      bit_cnt_next = bit_cnt_reg + CNT_W'(1);
      div_cnt_next = '0;
    end else if (in_shift) begin
      div_cnt_next = div_cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      div_cnt_reg <= div_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg        <= 1'b0;
      msb_first_reg <= 1'b0;
      data_reg      <= '0;
    end else if (cmd_fire) begin
      op_reg        <= cmd_op;
      msb_first_reg <= cmd_msb_first;
      data_reg      <= cmd_data;
    end
  end

  always_comb begin
    usr_s = MODE_HOLD;
    if (in_load && !abort) begin
      usr_s = MODE_LOAD;
    end else if (shift_cycle) begin
      usr_s = msb_first_reg ? MODE_LEFT : MODE_RIGHT;
    end
  end

  // RX loads zero so the received word is built on a clean register.
  assign usr_din = (in_load && !op_reg) ? data_reg : '0;

  assign ser_out = (in_shift && !op_reg) ?
                   (msb_first_reg ? usr_q[W-1] : usr_q[0]) : 1'b0;

  assign usr_sil = (in_shift && op_reg &&  msb_first_reg) ? ser_in : 1'b0;
  assign usr_sir = (in_shift && op_reg && !msb_first_reg) ? ser_in : 1'b0;

  assign cmd_ready = in_idle;
  assign bit_valid = in_shift;
  assign rsp_valid = in_resp;
  assign rsp_data  = in_resp ? usr_q : '0;

endmodule

// File: tb/tb_usr_seq.sv
// Bench for usr_seq: two instances (DIV=2 and DIV=1), each driving a small
// behavioural universal shift register whose contents feed back on usr_q.
module tb_usr_seq;

  localparam int W   = 4;
  localparam int DIV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cmd_valid, cmd_ready, cmd_op, cmd_msb_first;
  logic [W-1:0] cmd_data;
  logic         abort, ser_in, ser_out, bit_valid, rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data, usr_din, usr_q;
  logic [1:0]   usr_s;
  logic         usr_sil, usr_sir;

  logic         cmd_valid_b, cmd_ready_b, cmd_op_b, cmd_msb_first_b;
  logic [W-1:0] cmd_data_b;
  logic         abort_b, ser_in_b, ser_out_b, bit_valid_b, rsp_valid_b, rsp_ready_b;
  logic [W-1:0] rsp_data_b, usr_din_b, usr_q_b;
  logic [1:0]   usr_s_b;
  logic         usr_sil_b, usr_sir_b;

  usr_seq #(.W(W), .DIV(DIV)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_msb_first(cmd_msb_first), .cmd_data(cmd_data), .abort(abort),
    .ser_in(ser_in), .ser_out(ser_out), .bit_valid(bit_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .usr_s(usr_s), .usr_din(usr_din), .usr_sil(usr_sil), .usr_sir(usr_sir),
    .usr_q(usr_q)
  );

  usr_seq #(.W(W), .DIV(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op_b),
    .cmd_msb_first(cmd_msb_first_b), .cmd_data(cmd_data_b), .abort(abort_b),
    .ser_in(ser_in_b), .ser_out(ser_out_b), .bit_valid(bit_valid_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
    .usr_s(usr_s_b), .usr_din(usr_din_b), .usr_sil(usr_sil_b), .usr_sir(usr_sir_b),
    .usr_q(usr_q_b)
  );

  // Universal shift register models: 00 load, 01 toward MSB, 10 toward LSB, 11 hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      usr_q <= '0;
    end else begin
      case (usr_s)
        2'b00:   usr_q <= usr_din;
        2'b01:   usr_q <= {usr_q[W-2:0], usr_sil};
        2'b10:   usr_q <= {usr_sir, usr_q[W-1:1]};
        default: usr_q <= usr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      usr_q_b <= '0;
    end else begin
      case (usr_s_b)
        2'b00:   usr_q_b <= usr_din_b;
        2'b01:   usr_q_b <= {usr_q_b[W-2:0], usr_sil_b};
        2'b10:   usr_q_b <= {usr_sir_b, usr_q_b[W-1:1]};
        default: usr_q_b <= usr_q_b;
      endcase
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // sin / exp_ser are written in time order: leftmost bit is serial bit 0.
  typedef struct {
    logic         op;
    logic         msb;
    logic [W-1:0] data;
    logic [W-1:0] sin;
    logic [W-1:0] exp_ser;
    logic [W-1:0] exp_rsp;
    int           hold;
  } vec_t;

  vec_t vecs[8];

  // Entered and left on a negedge with the DUT in IDLE.
  task automatic run_txn(input vec_t v, input int idx);
    int k;
    int ph;
    chk("idle_ready", cmd_ready, 1);
    chk("idle_mode", usr_s, 2'b11);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_msb_first = v.msb; cmd_data = v.data;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = '0;
    chk("load_mode", usr_s, 2'b00);
    chk("load_din", usr_din, v.op ? 4'b0000 : v.data);
    chk("load_ready", cmd_ready, 0);
    for (int c = 2; c <= 1 + W * DIV; c++) begin
      @(negedge clk);
      k  = (c - 2) / DIV;
      ph = (c - 2) % DIV;
      ser_in = v.op ? v.sin[W-1-k] : 1'b0;
      #1;
      chk("shift_bit_valid", bit_valid, 1);
      chk("shift_rsp_valid", rsp_valid, 0);
      chk("shift_mode", usr_s, (ph == DIV - 1) ? (v.msb ? 2'b01 : 2'b10) : 2'b11);
      if (!v.op) chk("tx_ser_out", ser_out, v.exp_ser[W-1-k]);
      if (v.op && ph == DIV - 1) begin
        chk("rx_sil", usr_sil, v.msb ? v.sin[W-1-k] : 1'b0);
        chk("rx_sir", usr_sir, v.msb ? 1'b0 : v.sin[W-1-k]);
      end
    end
    @(negedge clk);
    ser_in = 1'b0;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, v.exp_rsp);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, v.exp_rsp);
      chk("hold_mode", usr_s, 2'b11);
      chk("hold_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_ready", cmd_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_rsp_data", rsp_data, 0);
    $display("txn %0d: op=%0d msb_first=%0d data=%b sin=%b rsp_expected=%b hold=%0d",
             idx, v.op, v.msb, v.data, v.sin, v.exp_rsp, v.hold);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 4'b1011, 4'b0000, 4'b1011, 4'b0000, 0};
    vecs[1] = '{1'b0, 1'b0, 4'b1011, 4'b0000, 4'b1101, 4'b0000, 0};
    vecs[2] = '{1'b1, 1'b0, 4'b1111, 4'b1101, 4'b0000, 4'b1011, 5};
    vecs[3] = '{1'b1, 1'b1, 4'b1111, 4'b0110, 4'b0000, 4'b0110, 0};
    vecs[4] = '{1'b0, 1'b1, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 0};
    vecs[5] = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 0};
    vecs[6] = '{1'b0, 1'b0, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 0};
    vecs[7] = '{1'b1, 1'b1, 4'b1010, 4'b1000, 4'b0000, 4'b1000, 0};

    cmd_valid = 0; cmd_op = 0; cmd_msb_first = 0; cmd_data = '0;
    abort = 0; ser_in = 0; rsp_ready = 0;
    cmd_valid_b = 0; cmd_op_b = 0; cmd_msb_first_b = 0; cmd_data_b = '0;
    abort_b = 0; ser_in_b = 0; rsp_ready_b = 0;

    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_mode", usr_s, 2'b11);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_din", usr_din, 0);
    chk("rst_sil_sir", {usr_sil, usr_sir}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back table transactions.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], i);
    end

    // Abort on the shift cycle of bit 2 of a TX (cycle 7).
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_msb_first = 1'b1; cmd_data = 4'b1011;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 2; c <= 7; c++) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_mode", usr_s, 2'b11);
    chk("abort_bit_valid", bit_valid, 1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_ready", cmd_ready, 1);
    chk("abort_idle_bit_valid", bit_valid, 0);
    for (int c = 0; c < 5; c++) begin
      chk("abort_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    $display("txn abort: TX 1011 msb_first aborted at bit 2");
    run_txn(vecs[0], 8);

    // Asynchronous reset mid-SHIFT.
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_msb_first = 1'b1; cmd_data = 4'b1011;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_mode", usr_s, 2'b11);
    chk("midrst_bit_valid", bit_valid, 0);
    chk("midrst_ser_out", ser_out, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", cmd_ready, 1);
    chk("postrst_bit_valid", bit_valid, 0);
    @(negedge clk);
    $display("txn reset: asynchronous reset during TX shift");
    run_txn(vecs[3], 9);

    // DIV=1 instance: RX MSB-first, ser_in 0,1,1,0 -> 0110, response in cycle 6.
    cmd_valid_b = 1'b1; cmd_op_b = 1'b1; cmd_msb_first_b = 1'b1; cmd_data_b = 4'b1111;
    chk("b_idle_ready", cmd_ready_b, 1);
    @(negedge clk);
    cmd_valid_b = 1'b0;
    chk("b_load_mode", usr_s_b, 2'b00);
    chk("b_load_din", usr_din_b, 0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      ser_in_b = (c == 3 || c == 4);
      #1;
      chk("b_shift_mode", usr_s_b, 2'b01);
      chk("b_sil", usr_sil_b, (c == 3 || c == 4) ? 1 : 0);
      chk("b_rsp_valid_early", rsp_valid_b, 0);
    end
    @(negedge clk);
    ser_in_b = 1'b0;
    chk("b_rsp_valid", rsp_valid_b, 1);
    chk("b_rsp_data", rsp_data_b, 4'b0110);
    rsp_ready_b = 1'b1;
    @(negedge clk);
    rsp_ready_b = 1'b0;
    chk("b_post_ready", cmd_ready_b, 1);
    $display("txn div1: RX msb_first ser_in 0110 rsp_expected=0110");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
